fft_frame_packer: RTL and testbench



---
 rtl/fft_frame_packer_if.sv | 15 +
 rtl/fft_frame_packer.sv | 126 ++++++++++++
 tb/tb_fft_frame_packer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_packer_if.sv
// AXI-Stream lane bundle (valid/data/keep/last/ready) shared by the packer's input and output.
// The master modport drives the beat; the slave modport drives ready.
interface fft_frame_packer_if #(
    parameter int BW  = 32,
    parameter int BWB = BW / 8
);
    logic           TVALID;
    logic [BW-1:0]  TDATA;
    logic [BWB-1:0] TKEEP;
    logic           TLAST;
    logic           TREADY;

    modport master (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);
endinterface

// File: rtl/fft_frame_packer.sv
// Packs an AXI-Stream sample stream into fixed N-sample FFT frames, zero-padding short packets.
// Latency 1 cycle (single output register); input stalls whenever that register cannot load or padding runs.
module fft_frame_packer #(
    parameter int BW     = 32,
    parameter int BWB    = BW / 8,
    parameter int LOG2_N = 8
) (
    input  logic                  clk_line,
    input  logic                  clk_line_rst_low,
    input  logic                  plain_start_of_processing,
    fft_frame_packer_if.slave     s,
    fft_frame_packer_if.master    m,
    output logic [15:0]           frame_count,
    output logic [15:0]           short_count,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic              m_vld_q, m_vld_d;
    logic [BW-1:0]     m_dat_q, m_dat_d;
    logic [BWB-1:0]    m_keep_q, m_keep_d;
    logic              m_last_q, m_last_d;
    logic [15:0]       frame_q, frame_d;
    logic [15:0]       short_q, short_d;

    logic load;
    logic s_rdy;
    logic accept;
    logic at_end;

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_vld_q  <= 1'b0;
            m_dat_q  <= '0;
            m_keep_q <= '0;
            m_last_q <= 1'b0;
            frame_q  <= '0;
            short_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_vld_q  <= m_vld_d;
            m_dat_q  <= m_dat_d;
            m_keep_q <= m_keep_d;
            m_last_q <= m_last_d;
            frame_q  <= frame_d;
            short_q  <= short_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_vld_d  = m_vld_q;
        m_dat_d  = m_dat_q;
        m_keep_d = m_keep_q;
        m_last_d = m_last_q;
        frame_d  = frame_q;
        short_d  = short_q;

        load   = !m_vld_q || m.TREADY;
        s_rdy  = (state_q == PASS) && load;
        accept = s.TVALID && s_rdy;
        at_end = (cnt_q == CNT_LAST);

        if (m_vld_q && m.TREADY && m_last_q) begin
            frame_d = frame_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (plain_start_of_processing) begin
                    state_d = PASS;
                end
            end
            PASS: begin
                if (load) begin
                    m_vld_d = accept;
                    if (accept) begin
                        m_dat_d  = s.TDATA;
                        m_keep_d = s.TKEEP;
                        m_last_d = at_end;
                        cnt_d    = cnt_q + LOG2_N'(1);
                        // A packet ending exactly on the frame boundary is a normal frame end.
                        if (s.TLAST && !at_end) begin
                            short_d = short_q + 16'd1;
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (load) begin
                    m_vld_d  = 1'b1;
                    m_dat_d  = '0;
                    m_keep_d = '1;
                    m_last_d = at_end;
                    cnt_d    = cnt_q + LOG2_N'(1);
                    if (at_end) begin
                        state_d = PASS;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s.TREADY    = s_rdy;
    assign m.TVALID    = m_vld_q;
    assign m.TDATA     = m_dat_q;
    assign m.TKEEP     = m_keep_q;
    assign m.TLAST     = m_last_q;
    assign frame_count = frame_q;
    assign short_count = short_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed bench for fft_frame_packer with N=8: reset, full frames, padding, random backpressure, restart.
module tb_fft_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] frame_count;
    logic [15:0] short_count;
    logic        busy;

    always #5 clk = ~clk;

    fft_frame_packer_if #(.BW(32), .BWB(4)) s_if ();
    fft_frame_packer_if #(.BW(32), .BWB(4)) m_if ();

    fft_frame_packer #(.BW(32), .BWB(4), .LOG2_N(3)) dut (
        .clk_line                  (clk),
        .clk_line_rst_low          (rst_n),
        .plain_start_of_processing (start),
        .s                         (s_if),
        .m                         (m_if),
        .frame_count               (frame_count),
        .short_count               (short_count),
        .busy                      (busy)
    );

    int checks   = 0;
    int failures = 0;
    int stall_bad;
    bit rand_rdy;

    // beats stored as {last, keep[3:0], data[31:0]}
    logic [36:0] src_q[$];
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() > 0) begin
            s_if.TVALID = 1'b1;
            {s_if.TLAST, s_if.TKEEP, s_if.TDATA} = src_q[0];
        end else begin
            s_if.TVALID = 1'b0;
            s_if.TDATA  = '0;
            s_if.TKEEP  = '0;
            s_if.TLAST  = 1'b0;
        end
    endtask

    task automatic tick();
        bit          acc_s;
        bit          stalled;
        logic [36:0] held;
        drive_src();
        #1;
        acc_s   = s_if.TVALID && s_if.TREADY;
        stalled = m_if.TVALID && !m_if.TREADY;
        held    = {m_if.TLAST, m_if.TKEEP, m_if.TDATA};
        if (m_if.TVALID && m_if.TREADY) got_q.push_back(held);
        if (stalled && s_if.TREADY) stall_bad++;
        @(posedge clk);
        #1;
        if (acc_s && src_q.size() > 0) void'(src_q.pop_front());
        if (stalled && (!m_if.TVALID || {m_if.TLAST, m_if.TKEEP, m_if.TDATA} != held)) stall_bad++;
        if (rand_rdy) m_if.TREADY = 1'($urandom_range(0, 1));
        drive_src();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rand_rdy = 1'b0;
        m_if.TREADY = 1'b1;
        stall_bad = 0;
        src_q.delete();
        got_q.delete();
        exp_q.delete();
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({l, k, d});
    endtask

    task automatic run_out(input string tag, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 64'(got_q.size() >= n), 64'd1);
        repeat (4) tick();
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        start = 1'b0;
        rand_rdy = 1'b0;
        stall_bad = 0;
        m_if.TREADY = 1'b1;
        drive_src();
        #12;
        chk("rst_m_vld",  64'(m_if.TVALID), 64'd0);
        chk("rst_m_dat",  64'(m_if.TDATA),  64'd0);
        chk("rst_m_keep", 64'(m_if.TKEEP),  64'd0);
        chk("rst_m_last", 64'(m_if.TLAST),  64'd0);
        chk("rst_s_rdy",  64'(s_if.TREADY), 64'd0);
        chk("rst_busy",   64'(busy),        64'd0);
        chk("rst_frames", 64'(frame_count), 64'd0);
        chk("rst_shorts", 64'(short_count), 64'd0);

        // Valid input but no start: nothing may move.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        src_q.push_back({1'b0, 4'hF, 32'h0000_00AA});
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_if.TREADY || m_if.TVALID || busy) bad++;
        end
        chk("idle_hold", 64'(bad), 64'd0);

        // Start held across reset release: first cycle after release accepts nothing.
        rst_n = 1'b0;
        src_q.delete();
        src_q.push_back({1'b0, 4'hF, 32'h0000_0055});
        start = 1'b1;
        drive_src();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_s_rdy", 64'(s_if.TREADY), 64'd0);
        tick();
        start = 1'b0;
        chk("rel_noacc", 64'(src_q.size()), 64'd1);
        chk("rel_busy",  64'(busy),         64'd1);

        // Two full frames, one 16-beat packet.
        do_reset();
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            src_q.push_back({(i == 16), 4'hF, 32'(i)});
            push_exp(32'(i), 4'hF, (i % 8) == 0);
        end
        drive_src();
        #1;
        chk("lat_pre_vld", 64'(m_if.TVALID), 64'd0);
        tick();
        chk("lat_vld", 64'(m_if.TVALID), 64'd1);
        chk("lat_dat", 64'(m_if.TDATA),  64'd1);
        run_out("full", 16, 100);
        compare("full");
        chk("full_frames", 64'(frame_count), 64'd2);
        chk("full_shorts", 64'(short_count), 64'd0);

        // Short packet padded to a frame; a queued beat must wait until padding ends.
        do_reset();
        pulse_start();
        src_q.push_back({1'b0, 4'hF, 32'h0000_000A});
        src_q.push_back({1'b0, 4'h3, 32'h0000_000B});
        src_q.push_back({1'b1, 4'hF, 32'h0000_000C});
        src_q.push_back({1'b0, 4'hF, 32'h0000_0077});
        push_exp(32'h0A, 4'hF, 1'b0);
        push_exp(32'h0B, 4'h3, 1'b0);
        push_exp(32'h0C, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) push_exp(32'h0, 4'hF, i == 4);
        push_exp(32'h77, 4'hF, 1'b0);
        run_out("pad", 9, 100);
        compare("pad");
        chk("pad_shorts", 64'(short_count), 64'd1);
        chk("pad_frames", 64'(frame_count), 64'd1);

        // Random backpressure over 64 beats.
        do_reset();
        pulse_start();
        rand_rdy = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            src_q.push_back({(i == 64), 4'hF, 32'h1000 + 32'(i)});
            push_exp(32'h1000 + 32'(i), 4'hF, (i % 8) == 0);
        end
        run_out("rnd", 64, 2000);
        rand_rdy = 1'b0;
        m_if.TREADY = 1'b1;
        repeat (3) tick();
        compare("rnd");
        chk("rnd_stall_hold", 64'(stall_bad), 64'd0);
        chk("rnd_frames",     64'(frame_count), 64'd8);

        // Reset mid-frame, then a clean restart.
        do_reset();
        pulse_start();
        for (int i = 1; i <= 5; i++) src_q.push_back({1'b0, 4'hF, 32'hD0 + 32'(i)});
        for (int i = 0; i < 20 && src_q.size() > 0; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_m_vld", 64'(m_if.TVALID), 64'd0);
        chk("midrst_busy",  64'(busy),        64'd0);
        do_reset();
        repeat (3) tick();
        chk("midrst_idle_vld", 64'(m_if.TVALID), 64'd0);
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            src_q.push_back({(i == 8), 4'hF, 32'hE0 + 32'(i)});
            push_exp(32'hE0 + 32'(i), 4'hF, i == 8);
        end
        run_out("restart", 8, 100);
        compare("restart");
        chk("restart_frames", 64'(frame_count), 64'd1);

        // Stray start during PASS, 9-beat packet: one full frame then a padded frame.
        do_reset();
        pulse_start();
        for (int i = 1; i <= 9; i++) begin
            src_q.push_back({(i == 9), 4'hF, 32'h60 + 32'(i)});
            push_exp(32'h60 + 32'(i), 4'hF, i == 8);
        end
        for (int i = 0; i < 7; i++) push_exp(32'h0, 4'hF, i == 6);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_out("nine", 16, 100);
        compare("nine");
        chk("nine_shorts", 64'(short_count), 64'd1);
        chk("nine_frames", 64'(frame_count), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
